// File: rtl/dense_pkg.sv
// Shared parameters, FSM state type, trained weight table and the Q8.8
// round/saturate helper for the 32-input dense layer.
package dense_pkg;

  localparam int N_IN   = 32;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int K_W    = $clog2(N_IN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } dense_state_t;

  // Retrained weights only ever touch this table.
  localparam logic signed [DATA_W-1:0] W_TABLE [N_IN] = '{
    16'sd37,   -16'sd52,  16'sd118,  -16'sd7,   16'sd196, -16'sd90,  16'sd14,   16'sd63,
    -16'sd128, 16'sd201,  -16'sd33,  16'sd75,   16'sd4,   -16'sd160, 16'sd99,   -16'sd21,
    16'sd142,  -16'sd66,  16'sd8,    16'sd230,  -16'sd115, 16'sd51,  -16'sd3,   16'sd88,
    -16'sd240, 16'sd17,   -16'sd181, 16'sd129,  -16'sd44, 16'sd70,   -16'sd96,  16'sd155
  };

  localparam logic signed [ACC_W-1:0] Q_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] Q_MIN = -40'sd32768;

  // Drops FRAC_W fraction bits (floor) and clamps into the Q8.8 range.
  function automatic logic [DATA_W-1:0] sat_q88(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC_W;
    if (r > Q_MAX)      return 16'h7FFF;
    else if (r < Q_MIN) return 16'h8000;
    else                return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dense_weight_rom.sv
// Combinational weight lookup: W[k] is available in the same cycle as k.
module dense_weight_rom
  import dense_pkg::*;
(
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] w
);

  assign w = W_TABLE[k];

endmodule

// File: rtl/dense_layer_ctrl.sv
// Sequencer for one 32-element dot product plus bias per start pulse,
// producing a saturated Q8.8 result behind a valid/ready output.
module dense_layer_ctrl
  import dense_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat moves on a rising edge where in_valid && in_ready;
  // the result moves where out_valid && out_ready; out_data is stable while
  // out_valid is high and unanswered.

  localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

  dense_state_t             state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        bias_q, bias_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  logic [DATA_W-1:0]        w;
  logic                     beat;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;

  dense_weight_rom u_rom (
    .k (k_q),
    .w (w)
  );

  assign beat     = in_valid && (state_q == ACCUM);
  assign prod     = $signed({{16{in_data[DATA_W-1]}}, in_data}) * $signed({{16{w[DATA_W-1]}}, w});
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  // Bias is aligned to the product scale (Q16.16) before the final shift.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (beat && (k_q == K_LAST)) state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d        = k_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    if ((state_q == IDLE) && start) begin
      k_d    = '0;
      acc_d  = '0;
      bias_d = bias;
    end
    if (beat) begin
      acc_d = acc_q + prod_ext;
      k_d   = (k_q == K_LAST) ? '0 : k_q + 1'b1;
    end
    if (state_q == FINAL) out_data_d = sat_q88(acc_q + bias_ext);
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == OUT);
    out_data  = out_data_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Bench for dense_layer_ctrl: scenario tasks drive vectors, a reference model
// pushes expected results into exp_q and outputs are popped on out_valid.
module tb_dense_layer_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        busy, in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] vec [N];
  logic [15:0] bias_v;

  logic signed [15:0] wt [N] = '{
    16'sd37,   -16'sd52,  16'sd118,  -16'sd7,   16'sd196, -16'sd90,  16'sd14,   16'sd63,
    -16'sd128, 16'sd201,  -16'sd33,  16'sd75,   16'sd4,   -16'sd160, 16'sd99,   -16'sd21,
    16'sd142,  -16'sd66,  16'sd8,    16'sd230,  -16'sd115, 16'sd51,  -16'sd3,   16'sd88,
    -16'sd240, 16'sd17,   -16'sd181, 16'sd129,  -16'sd44, 16'sd70,   -16'sd96,  16'sd155
  };

  dense_layer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model();
    longint acc;
    longint s;
    longint r;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'($signed(vec[i])) * longint'(wt[i]);
    s = acc + longint'($signed(bias_v)) * 256;
    r = s >>> 8;
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  task automatic set_onehot(input int idx, input logic [15:0] val);
    for (int i = 0; i < N; i++) vec[i] = 16'h0000;
    vec[idx] = val;
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
  endtask

  // driver: one full run with optional input gaps, output backpressure and stray starts
  task automatic run_vec(input int pct, input int hold, input bit start_in_accum,
                         input bit start_in_out, output logic [15:0] got);
    int c0;
    int k;
    int guard;
    bit acc_now;
    logic [15:0] held;
    logic [15:0] exp;
    exp_q.push_back(model());
    @(posedge clk); #1;
    start = 1'b1;
    bias  = bias_v;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL start_accept: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    k = 0;
    guard = 0;
    while (k < N && guard < 4000) begin
      in_valid = (pct >= 100) || ($urandom_range(0, 99) < pct);
      in_data  = vec[k];
      start    = start_in_accum && (k == 5);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc_now) k++;
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (k < N) begin
      n_errors++;
      $display("FAIL feed_timeout: accepted %0d beats required %0d", k, N);
    end
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (out_valid !== 1'b1 && guard < 200);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
    if (pct >= 100) begin
      n_checks++;
      if (cyc - c0 != N + 1) begin
        n_errors++;
        $display("FAIL latency: start-to-out_valid %0d cycles required %0d", cyc - c0, N + 1);
      end
    end
    // scoreboard
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: result 0x%h with no expected entry", out_data);
    end else begin
      exp = exp_q.pop_front();
      if (out_data !== exp) begin
        n_errors++;
        $display("FAIL result: out_data=0x%h required 0x%h", out_data, exp);
      end
    end
    got  = out_data;
    held = out_data;
    repeat (hold) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== held) begin
        n_errors++;
        $display("FAIL hold_stable: out_valid=%b busy=%b out_data=0x%h required 1 1 0x%h",
                 out_valid, busy, out_data, held);
      end
    end
    out_ready = 1'b1;
    start     = start_in_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL handshake_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
    if (start_in_out) begin
      repeat (3) begin
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_data !== held) begin
          n_errors++;
          $display("FAIL no_extra_run: busy=%b out_data=0x%h required 0 0x%h", busy, out_data, held);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
        dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL %s: busy=%b in_ready=%b out_valid=%b out_data=0x%h state=%0d required all 0",
               name, busy, in_ready, out_valid, out_data, dbg_state);
    end
  endtask

  task automatic check_const(input string name, input logic [15:0] got, input logic [15:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: out_data=0x%h required 0x%h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_zero();
    logic [15:0] got;
    for (int i = 0; i < N; i++) vec[i] = 16'h0000;
    bias_v = 16'h0100;
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("zero_input", got, 16'h0100);
  endtask

  task automatic test_onehot();
    logic [15:0] got;
    bias_v = 16'h0000;
    set_onehot(4, 16'h0100);
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("onehot_4", got, 16'h00C4);
    set_onehot(26, 16'h0100);
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("onehot_26", got, 16'hFF4B);
  endtask

  task automatic test_saturation();
    logic [15:0] got;
    bias_v = 16'h7FFF;
    set_onehot(4, 16'h7FFF);
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("sat_pos", got, 16'h7FFF);
    bias_v = 16'h8000;
    set_onehot(26, 16'h7FFF);
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("sat_neg", got, 16'h8000);
  endtask

  task automatic test_flow_random();
    logic [15:0] got_cont;
    logic [15:0] got_gap;
    for (int t = 0; t < 3; t++) begin
      set_random();
      for (int i = 0; i < N; i++) vec[i] = {{6{vec[i][9]}}, vec[i][9:0]};
      bias_v = 16'($urandom);
      run_vec(100, 0, 1'b0, 1'b0, got_cont);
      run_vec(50, 0, 1'b0, 1'b0, got_gap);
      check_const("gap_vs_continuous", got_gap, got_cont);
    end
  endtask

  task automatic test_out_backpressure();
    logic [15:0] got;
    set_random();
    bias_v = 16'h0040;
    run_vec(100, 5, 1'b0, 1'b0, got);
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    @(posedge clk); #1;
    start = 1'b1;
    bias  = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset_low");
    repeat (2) begin
      @(negedge clk);
      check_outputs_zero("mid_reset_hold");
    end
    rst_n = 1'b1;
    bias_v = 16'h0000;
    set_onehot(4, 16'h0100);
    run_vec(100, 0, 1'b0, 1'b0, got);
    check_const("after_mid_reset", got, 16'h00C4);
  endtask

  task automatic test_ignored_start();
    logic [15:0] got;
    bias_v = 16'h0000;
    set_onehot(26, 16'h0100);
    run_vec(100, 2, 1'b1, 1'b1, got);
    check_const("ignored_start", got, 16'hFF4B);
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    for (int t = 0; t < 3; t++) begin
      set_random();
      bias_v = 16'($urandom);
      run_vec(100, t, 1'b0, 1'b0, got);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_onehot();
    test_saturation();
    test_flow_random();
    test_out_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dense_layer_ctrl.md
# dense_layer_ctrl

Sequencer for the 32-input, single-output dense layer. It takes a 32-element signed Q8.8 activation vector as a stream. It pairs each element with its weight from the dense weight ROM, accumulates the products, adds a bias, then rounds and saturates the result to Q8.8. It sits between the recurrent cell's hidden-state output and the classifier output register, and sequences the ROM and MAC for one vector per `start`.

## Interface
- `N_IN`, 32, number of inputs and weights per run
- `DATA_W`, 16, activation, weight, bias and result width (signed two's complement)
- `FRAC_W`, 8, fractional bits in every DATA_W value (Q8.8)
- `ACC_W`, 40, accumulator width
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  one-cycle pulse that begins a run; sampled only in IDLE
- `bias`  in  DATA_W  layer bias; captured on the accepted `start`
- `busy`  out  1  high in every state except IDLE
- `in_valid`  in  1  activation beat valid
- `in_ready`  out  1  high only in ACCUM
- `in_data`  in  DATA_W  activation for the current index k
- `out_valid`  out  1  result valid; high only in OUT
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  DATA_W  saturated Q8.8 result

## Operation
- States: IDLE, ACCUM, FINAL, OUT.
- IDLE: `start` does four things. It clears `acc` to 0, clears `k` to 0, latches `bias` into `bias_q`, and moves the FSM to ACCUM.
- ACCUM: a beat is accepted when `in_valid && in_ready`. On each accepted beat:
  - acc += sext(in_data × W[k]), with the signed 32-bit product sign-extended to ACC_W.
  - k increments.
  - On the beat where k == N_IN−1, k wraps to 0 and the FSM moves to FINAL.
  - With `in_valid` low, acc and k hold and there is no timeout.
- FINAL: one cycle. It computes and registers the result:
  - s = acc + (sext(bias_q) <<< FRAC_W)
  - r = s >>> FRAC_W (arithmetic shift, truncation toward −∞)
  - out_data = r clamped to [−32768, 32767]
  - The FSM then moves to OUT.
- OUT: `out_valid` is high and `out_data` stays stable until `out_valid && out_ready`. On that edge the FSM returns to IDLE.
- `start` is ignored outside IDLE. A `start` in the same cycle as the OUT handshake is also ignored.
- Weight lookup W[k] is combinational on k; there is no read latency.
- ACC_W = 40 is enough for 32 worst-case products (2^30 × 2^5 < 2^39), so the accumulator never wraps.

## Timing
- Reset values: state = IDLE, acc = 0, k = 0, bias_q = 0.
- Output reset values: `busy` = 0, `in_ready` = 0, `out_valid` = 0, `out_data` = 0.
- Reset asserted mid-run aborts immediately. No partial result is ever emitted, and the next run starts clean.
- `start` accepted at edge E0: `busy` and `in_ready` are high from E0.
- Throughput is 1 beat per cycle with no bubbles. A back-to-back run takes N_IN beat cycles, plus FINAL, plus at least one OUT cycle.
- Last beat accepted at edge E: FINAL occupies the cycle after E, and `out_valid` rises at E+1.
- Minimum start-to-`out_valid` time is N_IN+1 cycles.
- `in_ready` drops at E, in the same edge that accepts the last beat.
- `out_data` holds its value outside OUT; it is only rewritten in FINAL.

## Structure
- Package `dense_pkg` holds:
  - the N_IN, DATA_W, FRAC_W and ACC_W localparams
  - the `dense_state_t` enum {IDLE, ACCUM, FINAL, OUT}
  - the 32-entry signed weight constant array
- Sub-module `dense_weight_rom`: a combinational k → W[k] lookup built on the package array. It is kept separate so retrained weights replace only the package constant.
- The saturate/shift logic is a package function `sat_q88(acc)`.

## Test plan
- **Zero input:** bias 0x0100, all 32 activations 0x0000 → out_data 0x0100, with `out_valid` exactly N_IN+1 cycles after `start` under continuous `in_valid`.
- **One-hot input:** bias 0, in[4] = 0x0100, others 0 → out_data 0x00C4 (W[4]). Repeat for in[26] = 0x0100 → 0xFF4B.
- **Saturation:**
  - bias 0x7FFF, in[4] = 0x7FFF, others 0 → 0x7FFF.
  - bias 0x8000, in[26] = 0x7FFF, others 0 → 0x8000.
- **Flow control:**
  - Toggle `in_valid` randomly at 50%; the result must match the continuous-input run for the same vector.
  - Hold `out_ready` low for 5 cycles; `out_data` and `out_valid` must stay stable, and `busy` must stay 1.
- **Reset mid-run:** pulse `rst_n` low after 10 accepted beats. All outputs must be 0 while reset is low. A following full run with the one-hot in[4] = 0x0100 vector must give 0x00C4.
- **Ignored start:** pulse `start` during ACCUM and during OUT; the run must be unaffected and no extra run may begin after the return to IDLE.
